mem_port_arbiter: RTL and testbench

Arbitrates the single data-side port of the shared block memory between two requesters: the CPU load/store path and the return-address-stack (RAS) spill/fill engine. It sits between the CPU/RAS requesters and the shared memory interface. It replaces the current scheme, where RAS traffic only gets idle cycles and CPU hold is never asserted. CPU has priority, but a bounded-wait rule forces a RAS grant, optionally locked for a burst, and stalls the CPU through `cpu_hold`.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the data-side memory port arbiter: FSM state encoding,
// the store-control codes driven for RAS beats, and the counter widths.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // S_CPU  : CPU has priority, RAS waits (bounded by MAX_WAIT)
  // S_RAS  : locked RAS burst in progress, CPU is held
  // S_COOL : one cycle in which the CPU is guaranteed the port
  typedef enum logic [1:0] {
    S_CPU  = 2'b00,
    S_RAS  = 2'b01,
    S_COOL = 2'b10
  } arb_state_e;

  // RAS beats are always full-word, so the store control is fixed.
  localparam logic [2:0] RAS_STRCTRL_WR = 3'b100;
  localparam logic [2:0] RAS_STRCTRL_RD = 3'b000;

  // wait_cnt covers MAX_WAIT up to 15, burst_cnt covers MAX_BURST up to 16.
  localparam int WAIT_W  = 4;
  localparam int BURST_W = 5;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates the single data-side port of the shared block memory between the
// CPU load/store path and the return-address-stack spill/fill engine.
// The CPU wins by default; a RAS request that has lost MAX_WAIT consecutive
// cycles is forced through, optionally as a locked burst of up to MAX_BURST
// beats, while the CPU is stalled via cpu_hold. Every forced episode ends with
// one S_COOL cycle in which the CPU is guaranteed service.
//
// Parameters
//   MAX_WAIT   : cycles a pending RAS request may lose before a forced grant
//   MAX_BURST  : maximum RAS beats in one locked burst
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cpu_rd / cpu_wr            : CPU request (both set is treated as a write)
//   cpu_addr/din/wen/strctrl   : CPU access attributes
//   cpu_hold                   : CPU request not serviced this cycle
//   cpu_dout                   : read data, one cycle after a serviced read
//   ras_req / ras_wr / ras_lock: RAS beat request, direction, burst hint
//   ras_addr / ras_din         : RAS address and full-word write data
//   ras_gnt                    : RAS beat accepted this cycle
//   ras_rvalid / ras_dout      : RAS read data, one cycle after a granted read
//   mem_*                      : memory port (combinational mux)
//   mem_dout                   : memory read data, 1-cycle latency
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [3:0]  cpu_wen,
  input  logic [2:0]  cpu_strctrl,
  output logic        cpu_hold,
  output logic [31:0] cpu_dout,

  input  logic        ras_req,
  input  logic        ras_wr,
  input  logic        ras_lock,
  input  logic [31:0] ras_addr,
  input  logic [31:0] ras_din,
  output logic        ras_gnt,
  output logic        ras_rvalid,
  output logic [31:0] ras_dout,

  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_strctrl,
  input  logic [31:0] mem_dout
);

  localparam logic [WAIT_W-1:0]  MAX_WAIT_C  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);
  // A burst of one beat is just a single forced grant; never enter S_RAS.
  localparam logic               LOCK_OK_C   = (MAX_BURST > 1) ? 1'b1 : 1'b0;

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rd_is_ras_q, rd_is_ras_d;

  logic               cpu_req_s;
  logic               forced_s;
  logic               ras_gnt_s;
  logic [BURST_W-1:0] burst_inc_s;

  // Grant decision: zero-latency, derived from current state and requests.
  always_comb begin
    cpu_req_s = cpu_rd | cpu_wr;
    forced_s  = (state_q == S_RAS) |
                ((state_q == S_CPU) & (wait_cnt_q == MAX_WAIT_C));
    // S_COOL belongs to the CPU; RAS may only use it if the CPU is idle.
    ras_gnt_s = ras_req & (~cpu_req_s | forced_s) &
                ((state_q != S_COOL) | ~cpu_req_s);
  end

  assign ras_gnt  = ras_gnt_s;
  assign cpu_hold = cpu_req_s & ras_gnt_s;

  // Memory port mux: the granted RAS beat, otherwise the CPU pass-through.
  always_comb begin
    if (ras_gnt_s) begin
      mem_en      = 1'b1;
      mem_addr    = ras_addr;
      mem_din     = ras_din;
      mem_wen     = ras_wr ? 4'hF : 4'h0;
      mem_strctrl = ras_wr ? RAS_STRCTRL_WR : RAS_STRCTRL_RD;
    end else begin
      mem_en      = cpu_req_s;
      mem_addr    = cpu_addr;
      mem_din     = cpu_din;
      // cpu_wr wins when both cpu_rd and cpu_wr are set.
      mem_wen     = cpu_wr ? cpu_wen : 4'h0;
      mem_strctrl = cpu_strctrl;
    end
  end

  // Read data is shared; ras_rvalid tells the RAS engine the beat was its own.
  assign cpu_dout   = mem_dout;
  assign ras_dout   = mem_dout;
  assign ras_rvalid = rd_is_ras_q;

  // Starvation counter: counts S_CPU cycles a pending RAS request loses.
  always_comb begin
    if (ras_gnt_s || !ras_req) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if (state_q == S_CPU) begin
      if (wait_cnt_q < MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      // A RAS request losing to the CPU in S_COOL does not age.
      wait_cnt_d = wait_cnt_q;
    end
  end

  // FSM next state and burst beat counting.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    burst_inc_s = burst_cnt_q + {{(BURST_W-1){1'b0}}, 1'b1};
    rd_is_ras_d = ras_gnt_s & ~ras_wr;

    case (state_q)
      S_CPU: begin
        // Unforced grants (CPU idle) keep the arbiter in S_CPU.
        if (forced_s && ras_gnt_s) begin
          if (ras_lock && LOCK_OK_C) begin
            state_d     = S_RAS;
            burst_cnt_d = {{(BURST_W-1){1'b0}}, 1'b1};
          end else begin
            state_d     = S_COOL;
            burst_cnt_d = {BURST_W{1'b0}};
          end
        end else begin
          state_d = S_CPU;
        end
      end

      S_RAS: begin
        // In S_RAS the grant only drops when ras_req drops.
        if (ras_gnt_s) begin
          burst_cnt_d = burst_inc_s;
          // The beat carrying ras_lock=0 is still served, then the burst ends.
          if (ras_lock && (burst_inc_s < MAX_BURST_C)) begin
            state_d = S_RAS;
          end else begin
            state_d = S_COOL;
          end
        end else begin
          state_d = S_COOL;
        end
      end

      S_COOL: begin
        state_d     = S_CPU;
        burst_cnt_d = {BURST_W{1'b0}};
      end

      default: begin
        state_d     = S_CPU;
        burst_cnt_d = {BURST_W{1'b0}};
      end
    endcase
  end

  // State registers; reset drops any RAS read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CPU;
      wait_cnt_q  <= {WAIT_W{1'b0}};
      burst_cnt_q <= {BURST_W{1'b0}};
      rd_is_ras_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_is_ras_q <= rd_is_ras_d;
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MAX_WAIT=4, MAX_BURST=8).
// A behavioural memory with 1-cycle read latency sits on the memory port;
// expected RAS read data is queued when a RAS read is granted and compared
// when ras_rvalid appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_din;
  logic [3:0]  cpu_wen;
  logic [2:0]  cpu_strctrl;
  logic        cpu_hold;
  logic [31:0] cpu_dout;
  logic        ras_req, ras_wr, ras_lock;
  logic [31:0] ras_addr, ras_din;
  logic        ras_gnt, ras_rvalid;
  logic [31:0] ras_dout;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_din;
  logic [2:0]  mem_strctrl;
  logic [31:0] mem_dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_arr[logic [31:0]];

  mem_port_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_wen(cpu_wen), .cpu_strctrl(cpu_strctrl), .cpu_hold(cpu_hold),
    .cpu_dout(cpu_dout),
    .ras_req(ras_req), .ras_wr(ras_wr), .ras_lock(ras_lock),
    .ras_addr(ras_addr), .ras_din(ras_din), .ras_gnt(ras_gnt),
    .ras_rvalid(ras_rvalid), .ras_dout(ras_dout),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_strctrl(mem_strctrl), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background contents of never-written locations.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Behavioural memory: read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      logic [31:0] cur;
      cur = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : pat(mem_addr);
      mem_dout <= cur;
      if (|mem_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wen[b]) cur[8*b +: 8] = mem_din[8*b +: 8];
        end
        mem_arr[mem_addr] = cur;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer for RAS read returns.
  always @(negedge clk) begin
    if (ras_rvalid) begin
      if (exp_q.size() == 0) check("ras_rvalid_unexpected", 64'(ras_rvalid), 64'd0);
      else check("ras_dout", 64'(ras_dout), 64'(exp_q.pop_front()));
    end
  end

  task automatic clear_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_din = 32'h0;
    cpu_wen = 4'h0; cpu_strctrl = 3'b000;
    ras_req = 1'b0; ras_wr = 1'b0; ras_lock = 1'b0;
    ras_addr = 32'h0; ras_din = 32'h0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    logic exp_g;
    mem_dout = 32'h0;
    rst_n = 1'b0;
    clear_inputs();

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_state", 64'(dut.state_q), 64'(S_CPU));
    check("rst_wait_cnt", 64'(dut.wait_cnt_q), 64'd0);
    check("rst_burst_cnt", 64'(dut.burst_cnt_q), 64'd0);
    check("rst_ras_rvalid", 64'(ras_rvalid), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_ras_gnt", 64'(ras_gnt), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    drive_edge();
    rst_n = 1'b1;
    drive_edge();

    // ---------------- unforced RAS write, CPU idle ----------------
    ras_req = 1'b1; ras_wr = 1'b1; ras_addr = 32'h0000_2010; ras_din = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_wr_gnt", 64'(ras_gnt), 64'd1);
    check("idle_wr_hold", 64'(cpu_hold), 64'd0);
    check("idle_wr_mem_en", 64'(mem_en), 64'd1);
    check("idle_wr_mem_wen", 64'(mem_wen), 64'hF);
    check("idle_wr_strctrl", 64'(mem_strctrl), 64'(3'b100));
    check("idle_wr_addr", 64'(mem_addr), 64'h2010);
    check("idle_wr_din", 64'(mem_din), 64'hDEAD_BEEF);
    drive_edge();
    check("idle_wr_state", 64'(dut.state_q), 64'(S_CPU));
    // read the word back through RAS
    ras_wr = 1'b0;
    @(negedge clk);
    check("idle_rd_gnt", 64'(ras_gnt), 64'd1);
    check("idle_rd_mem_wen", 64'(mem_wen), 64'h0);
    check("idle_rd_strctrl", 64'(mem_strctrl), 64'(3'b000));
    if (ras_gnt) exp_q.push_back(32'hDEAD_BEEF);
    drive_edge();
    clear_inputs();
    @(negedge clk);
    check("idle_rd_rvalid", 64'(ras_rvalid), 64'd1);
    check("idle_rd_state", 64'(dut.state_q), 64'(S_CPU));
    drive_edge();

    // ---------------- bounded wait: CPU read vs RAS read ----------------
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0100;
    ras_req = 1'b1; ras_wr = 1'b0; ras_lock = 1'b0; ras_addr = 32'h0000_3000;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp_g = (c == 4);
      check($sformatf("bw_gnt_c%0d", c), 64'(ras_gnt), 64'(exp_g));
      check($sformatf("bw_hold_c%0d", c), 64'(cpu_hold), 64'(exp_g));
      check($sformatf("bw_addr_c%0d", c), 64'(mem_addr), exp_g ? 64'h3000 : 64'h100);
      if (ras_gnt) exp_q.push_back(pat(32'h0000_3000));
      if (c >= 1 && c <= 4) check($sformatf("bw_cpu_dout_c%0d", c), 64'(cpu_dout), 64'(pat(32'h0000_0100)));
      if (c == 5) begin
        check("bw_cool_state", 64'(dut.state_q), 64'(S_COOL));
        check("bw_cool_rvalid", 64'(ras_rvalid), 64'd1);
      end
      drive_edge();
    end
    clear_inputs();
    drive_edge();

    // ---------------- locked burst of 10 beats, MAX_BURST=8 ----------------
    cpu_wr = 1'b1; cpu_addr = 32'h0000_0400; cpu_din = 32'h1122_3344;
    cpu_wen = 4'hF; cpu_strctrl = 3'b010;
    ras_wr = 1'b1; ras_lock = 1'b1;
    beats = 0;
    for (int c = 0; c <= 21; c++) begin
      ras_req  = (beats < 10);
      ras_addr = 32'h0000_5000 + 32'(4 * beats);
      ras_din  = 32'hB000_0000 + 32'(beats);
      @(negedge clk);
      exp_g = (c >= 4 && c <= 11) || c == 17 || c == 18;
      check($sformatf("burst_gnt_c%0d", c), 64'(ras_gnt), 64'(exp_g));
      check($sformatf("burst_hold_c%0d", c), 64'(cpu_hold), 64'(exp_g));
      if (c == 12) check("burst_cool_state", 64'(dut.state_q), 64'(S_COOL));
      if (ras_gnt) beats++;
      drive_edge();
    end
    check("burst_beats", 64'(beats), 64'd10);
    clear_inputs();
    drive_edge();

    // ---------------- ras_lock drops on beat 3 ----------------
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0104;
    ras_wr = 1'b0;
    beats = 0;
    for (int c = 0; c <= 7; c++) begin
      ras_req  = (beats < 3);
      ras_lock = (beats < 2);
      ras_addr = 32'h0000_6000 + 32'(4 * beats);
      @(negedge clk);
      exp_g = (c >= 4 && c <= 6);
      check($sformatf("ldrop_gnt_c%0d", c), 64'(ras_gnt), 64'(exp_g));
      if (ras_gnt) begin
        exp_q.push_back(pat(ras_addr));
        beats++;
      end
      if (c == 7) begin
        check("ldrop_state", 64'(dut.state_q), 64'(S_COOL));
        check("ldrop_wait_cnt", 64'(dut.wait_cnt_q), 64'd0);
        check("ldrop_hold", 64'(cpu_hold), 64'd0);
      end
      drive_edge();
    end
    clear_inputs();
    drive_edge();

    // ---------------- asynchronous reset during beat 5 ----------------
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0108;
    ras_wr = 1'b0; ras_lock = 1'b1; ras_req = 1'b1;
    beats = 0;
    for (int c = 0; c <= 8; c++) begin
      ras_addr = 32'h0000_7000 + 32'(4 * beats);
      @(negedge clk);
      check($sformatf("arst_gnt_c%0d", c), 64'(ras_gnt), 64'(c >= 4));
      if (ras_gnt) begin
        if (beats < 4) exp_q.push_back(pat(ras_addr));
        beats++;
      end
      if (c < 8) drive_edge();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(dut.state_q), 64'(S_CPU));
    check("arst_hold", 64'(cpu_hold), 64'd0);
    check("arst_rvalid", 64'(ras_rvalid), 64'd0);
    check("arst_burst_cnt", 64'(dut.burst_cnt_q), 64'd0);
    clear_inputs();
    drive_edge();
    rst_n = 1'b1;
    drive_edge();
    drive_edge();

    // ---------------- cpu_rd and cpu_wr both set ----------------
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_wen = 4'b0011;
    cpu_addr = 32'h0000_0500; cpu_din = 32'hCAFE_F00D; cpu_strctrl = 3'b001;
    @(negedge clk);
    check("both_mem_en", 64'(mem_en), 64'd1);
    check("both_mem_wen", 64'(mem_wen), 64'(4'b0011));
    check("both_hold", 64'(cpu_hold), 64'd0);
    check("both_gnt", 64'(ras_gnt), 64'd0);
    check("both_strctrl", 64'(mem_strctrl), 64'(3'b001));
    check("both_din", 64'(mem_din), 64'hCAFE_F00D);
    drive_edge();
    clear_inputs();
    drive_edge();
    drive_edge();
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
